// File: rtl/multiplicador_n_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// The state encoding is shared so the top FSM and any observer agree on it.
package multiplicador_n_pkg;

   localparam int MULT_N_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } estado_t;

endpackage

// File: rtl/multiplicador_n_datos.sv
// Datapath of the shift-add multiplier: sign/magnitude capture, one add-shift step
// per CALC cycle, and the final sign fix-up written into the product register.
module multiplicador_n_datos #(
   parameter int N  = 8,
   parameter int CW = $clog2(N + 1)
) (
   input  logic           clk,
   input  logic           clr,
   input  logic           load,
   input  logic           step,
   input  logic           wr,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           signo,
   output logic           last,
   output logic [2*N-1:0] mult
);

   localparam int PW = 2 * N;

   logic [N-1:0]  mcnd;
   logic [N-1:0]  mplr;
   logic [N:0]    acc;
   logic [CW-1:0] cnt;
   logic          neg;

   logic [N-1:0]  a_mag;
   logic [N-1:0]  b_mag;
   logic [N:0]    sum;
   logic [N:0]    acc_nx;
   logic [N-1:0]  mplr_nx;
   logic [PW-1:0] prod;
   logic [PW-1:0] res;

   // Magnitudes are kept unsigned N-bit, so the most-negative value maps to 2^(N-1).
   always_comb begin
      a_mag   = (signo && a[N-1]) ? (~a) + N'(1) : a;
      b_mag   = (signo && b[N-1]) ? (~b) + N'(1) : b;
      sum     = acc + (mplr[0] ? {1'b0, mcnd} : '0);
      acc_nx  = {1'b0, sum[N:1]};
      mplr_nx = {sum[0], mplr[N-1:1]};
      prod    = {acc_nx[N-1:0], mplr_nx};
      res     = neg ? (~prod) + PW'(1) : prod;
      last    = (cnt == CW'(N - 1));
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         mcnd <= '0;
         mplr <= '0;
         acc  <= '0;
         cnt  <= '0;
         neg  <= 1'b0;
         mult <= '0;
      end else begin
         if (load) begin
            mcnd <= a_mag;
            mplr <= b_mag;
            acc  <= '0;
            cnt  <= '0;
            neg  <= signo & (a[N-1] ^ b[N-1]);
         end else if (step) begin
            acc  <= acc_nx;
            mplr <= mplr_nx;
            cnt  <= cnt + CW'(1);
         end
         // Result is taken from the post-step value so the final step and the write share one edge.
         if (wr) begin
            mult <= res;
         end
      end
   end

endmodule

// File: rtl/multiplicador_n.sv
// Sequential N-bit signed/unsigned multiplier: N+1 edges from start to fin.
// Control FSM lives here; the arithmetic is in multiplicador_n_datos.
module multiplicador_n
   import multiplicador_n_pkg::*;
#(
   parameter int N  = MULT_N_DEF,
   parameter int CW = $clog2(N + 1)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           signo,
   input  logic           xs,
   output logic           busy,
   output logic           fin,
   output logic [2*N-1:0] mult
);

   estado_t st;
   logic    load;
   logic    step;
   logic    wr;
   logic    last;

   assign load = (st == IDLE) && xs;
   assign step = (st == CALC);
   assign wr   = step && last;

   always_ff @(posedge clk) begin
      if (reset) begin
         st   <= IDLE;
         busy <= 1'b0;
         fin  <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               if (xs) begin
                  st   <= CALC;
                  busy <= 1'b1;
               end
            end
            CALC: begin
               if (last) begin
                  st   <= DONE;
                  busy <= 1'b0;
                  fin  <= 1'b1;
               end
            end
            DONE: begin
               // A held start must not retrigger; wait for xs to drop.
               if (!xs) begin
                  st  <= IDLE;
                  fin <= 1'b0;
               end
            end
            default: begin
               st   <= IDLE;
               busy <= 1'b0;
               fin  <= 1'b0;
            end
         endcase
      end
   end

   multiplicador_n_datos #(
      .N  (N),
      .CW (CW)
   ) u_datos (
      .clk   (clk),
      .clr   (reset),
      .load  (load),
      .step  (step),
      .wr    (wr),
      .a     (a),
      .b     (b),
      .signo (signo),
      .last  (last),
      .mult  (mult)
   );

endmodule

// File: tb/tb_multiplicador_n.sv
// Scoreboard bench: stimulus pushes expected products and due cycles, per-width monitors check on fin.
module tb_multiplicador_n;

   typedef struct {
      logic [63:0] v;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   failed = 0;

   logic [3:0]  a4 = '0,  b4 = '0;
   logic [7:0]  a8 = '0,  b8 = '0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        s4 = 0, s8 = 0, s16 = 0;
   logic        xs4 = 0, xs8 = 0, xs16 = 0;
   logic        busy4, busy8, busy16;
   logic        fin4, fin8, fin16;
   logic [7:0]  mult4;
   logic [15:0] mult8;
   logic [31:0] mult16;

   exp_t q4[$];
   exp_t q8[$];
   exp_t q16[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multiplicador_n #(.N(4)) u4 (
      .clk(clk), .reset(reset), .a(a4), .b(b4), .signo(s4), .xs(xs4),
      .busy(busy4), .fin(fin4), .mult(mult4)
   );
   multiplicador_n #(.N(8)) u8 (
      .clk(clk), .reset(reset), .a(a8), .b(b8), .signo(s8), .xs(xs8),
      .busy(busy8), .fin(fin8), .mult(mult8)
   );
   multiplicador_n #(.N(16)) u16 (
      .clk(clk), .reset(reset), .a(a16), .b(b16), .signo(s16), .xs(xs16),
      .busy(busy16), .fin(fin16), .mult(mult16)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] refm(input int n, input logic [31:0] av, input logic [31:0] bv,
                                        input bit s);
      longint x, y;
      logic [63:0] p;
      x = longint'(av);
      y = longint'(bv);
      if (s && av[n-1]) x = x - (longint'(1) << n);
      if (s && bv[n-1]) y = y - (longint'(1) << n);
      p = 64'(x * y);
      return p & ((64'd1 << (2 * n)) - 64'd1);
   endfunction

   function automatic logic fin_of(input int w);
      case (w)
         4:       return fin4;
         8:       return fin8;
         default: return fin16;
      endcase
   endfunction

   function automatic logic busy_of(input int w);
      case (w)
         4:       return busy4;
         8:       return busy8;
         default: return busy16;
      endcase
   endfunction

   task automatic set_xs(input int w, input logic v);
      case (w)
         4:       xs4 = v;
         8:       xs8 = v;
         default: xs16 = v;
      endcase
   endtask

   task automatic wait_fin(input int w);
      bit got = 0;
      for (int i = 0; i < w + 4 && !got; i++) begin
         @(negedge clk);
         got = fin_of(w);
      end
      chk($sformatf("fin_seen_n%0d", w), 64'(got), 64'd1);
   endtask

   // One operation on DUT of width w; returns at the first negedge showing fin.
   task automatic run(input int w, input logic [31:0] av, input logic [31:0] bv, input bit sv,
                      input logic [63:0] ev, input bit hold);
      exp_t e;
      @(negedge clk);
      e.v   = ev;
      e.due = cyc + 1 + w;
      case (w)
         4: begin
            a4 = av[3:0]; b4 = bv[3:0]; s4 = sv; q4.push_back(e);
         end
         8: begin
            a8 = av[7:0]; b8 = bv[7:0]; s8 = sv; q8.push_back(e);
         end
         default: begin
            a16 = av[15:0]; b16 = bv[15:0]; s16 = sv; q16.push_back(e);
         end
      endcase
      set_xs(w, 1'b1);
      @(negedge clk);
      chk($sformatf("busy_calc_n%0d", w), 64'(busy_of(w)), 64'd1);
      if (!hold) set_xs(w, 1'b0);
      wait_fin(w);
   endtask

   logic fin4_q = 0, fin8_q = 0, fin16_q = 0;
   exp_t m4, m8, m16;

   always @(negedge clk) begin
      if (fin4 && !fin4_q) begin
         if (q4.size() == 0) begin
            tests++; failed++;
            $display("FAIL spurious_fin_n4: fin=1 with nothing expected (cycle %0d)", cyc);
         end else begin
            m4 = q4.pop_front();
            chk("mult_n4", 64'(mult4), m4.v);
            chk("latency_n4", 64'(cyc), 64'(m4.due));
         end
      end
      fin4_q = fin4;
   end

   always @(negedge clk) begin
      if (fin8 && !fin8_q) begin
         if (q8.size() == 0) begin
            tests++; failed++;
            $display("FAIL spurious_fin_n8: fin=1 with nothing expected (cycle %0d)", cyc);
         end else begin
            m8 = q8.pop_front();
            chk("mult_n8", 64'(mult8), m8.v);
            chk("latency_n8", 64'(cyc), 64'(m8.due));
         end
      end
      fin8_q = fin8;
   end

   always @(negedge clk) begin
      if (fin16 && !fin16_q) begin
         if (q16.size() == 0) begin
            tests++; failed++;
            $display("FAIL spurious_fin_n16: fin=1 with nothing expected (cycle %0d)", cyc);
         end else begin
            m16 = q16.pop_front();
            chk("mult_n16", 64'(mult16), m16.v);
            chk("latency_n16", 64'(cyc), 64'(m16.due));
         end
      end
      fin16_q = fin16;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      bit rs;

      repeat (3) @(negedge clk);
      chk("reset_busy8", 64'(busy8), 64'd0);
      chk("reset_fin8", 64'(fin8), 64'd0);
      chk("reset_mult8", 64'(mult8), 64'd0);
      chk("reset_busy4", 64'(busy4), 64'd0);
      chk("reset_mult16", 64'(mult16), 64'd0);
      reset = 1'b0;

      // Unsigned max with xs held through DONE.
      run(8, 32'hFF, 32'hFF, 1'b0, 64'hFE01, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("fin_held", 64'(fin8), 64'd1);
         chk("mult_held", 64'(mult8), 64'hFE01);
      end
      xs8 = 1'b0;
      @(negedge clk);
      chk("idle_fin", 64'(fin8), 64'd0);
      chk("idle_busy", 64'(busy8), 64'd0);
      chk("idle_mult_kept", 64'(mult8), 64'hFE01);

      run(8, 32'h00, 32'h85, 1'b1, 64'h0000, 1'b0);
      run(8, 32'hFD, 32'h07, 1'b1, 64'hFFEB, 1'b0);
      run(8, 32'h80, 32'h80, 1'b1, 64'h4000, 1'b0);

      // Abort at the 4th CALC edge.
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; s8 = 1'b0; xs8 = 1'b1;
      @(negedge clk);
      xs8 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 64'(busy8), 64'd0);
      chk("abort_fin", 64'(fin8), 64'd0);
      chk("abort_mult", 64'(mult8), 64'd0);
      reset = 1'b1; xs8 = 1'b1;
      @(negedge clk);
      reset = 1'b0; xs8 = 1'b0;
      chk("reset_beats_xs", 64'(busy8), 64'd0);
      run(8, 32'h12, 32'h34, 1'b0, 64'h03A8, 1'b0);

      // Operand and xs churn while calculating.
      @(negedge clk);
      a8 = 8'h23; b8 = 8'h11; s8 = 1'b0; xs8 = 1'b1;
      q8.push_back('{64'h0253, cyc + 1 + 8});
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         a8  = 8'($urandom);
         b8  = 8'($urandom);
         s8  = ~s8;
         xs8 = (i < 5) ? i[0] : 1'b0;
      end
      xs8 = 1'b0;
      wait_fin(8);
      repeat (4) begin
         @(negedge clk);
         chk("no_retrigger", 64'(busy8), 64'd0);
      end

      // Width sweep against the reference model.
      run(4, 32'h8, 32'h8, 1'b1, 64'h40, 1'b0);
      run(16, 32'h8000, 32'h8000, 1'b1, 64'h40000000, 1'b0);
      for (int i = 0; i < 8; i++) begin
         ra = $urandom & 32'hF;
         rb = $urandom & 32'hF;
         rs = 1'($urandom_range(0, 1));
         run(4, ra, rb, rs, refm(4, ra, rb, rs), 1'b0);
         ra = $urandom & 32'hFFFF;
         rb = $urandom & 32'hFFFF;
         rs = 1'($urandom_range(0, 1));
         run(16, ra, rb, rs, refm(16, ra, rb, rs), 1'b0);
      end

      repeat (4) @(negedge clk);
      chk("drain_q4", 64'(q4.size()), 64'd0);
      chk("drain_q8", 64'(q8.size()), 64'd0);
      chk("drain_q16", 64'(q16.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
